// File: rtl/cci_rd_arbiter_if.sv
// Request/response bundle between the read requesters, the CCI-P c0 read path and cci_rd_arbiter.
// The master modport is the arbiter's view; slave is the environment's mirror of it.
interface cci_rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 42
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_grant;

    logic                      out_rd_en;
    logic [ADDR_W-1:0]         out_rd_addr;
    logic [15:0]               out_rd_mdata;
    logic                      rd_almfull;

    logic                      in_rsp_valid;
    logic [15:0]               in_rsp_mdata;
    logic [511:0]              in_rsp_data;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [511:0]              rsp_data;

    modport master (
        input  req_valid, req_addr, rd_almfull, in_rsp_valid, in_rsp_mdata, in_rsp_data,
        output req_grant, out_rd_en, out_rd_addr, out_rd_mdata, rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_addr, rd_almfull, in_rsp_valid, in_rsp_mdata, in_rsp_data,
        input  req_grant, out_rd_en, out_rd_addr, out_rd_mdata, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cci_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0Tx read channel, with mdata tagging, credits and response routing.
// Optional per-requester grant/stall counters are enabled by defining CCI_RD_ARB_PERF_EN.
module cci_rd_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_W          = 42,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    cci_rd_arbiter_if.master      bus,
    output logic [9:0]            outstanding,
    output logic                  idle,
    output logic                  err
`ifdef CCI_RD_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_grants,
    output logic [31:0]           perf_stall
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             grant_any;
    logic             eligible;
    logic             rsp_tag_ok;
    logic [PTR_W-1:0] rsp_idx;

    // A response returning this cycle frees its credit in time for a grant at the limit.
    assign eligible = !bus.rd_almfull &&
                      ((outstanding < 10'(MAX_OUTSTANDING)) || bus.in_rsp_valid);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_any     = 1'b0;
        grant_idx     = '0;
        bus.req_grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (eligible && !grant_any && bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
        if (grant_any) bus.req_grant[grant_idx] = 1'b1;
    end

    assign next_ptr   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    assign rsp_tag_ok = (bus.in_rsp_mdata[15:4] == 12'd0) &&
                        ({1'b0, bus.in_rsp_mdata[3:0]} < 5'(NUM_REQ));
    assign rsp_idx    = bus.in_rsp_mdata[PTR_W-1:0];
    assign idle       = (outstanding == 10'd0) && !bus.out_rd_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr              <= '0;
            bus.out_rd_en    <= 1'b0;
            bus.out_rd_addr  <= '0;
            bus.out_rd_mdata <= '0;
            bus.rsp_valid    <= '0;
            // NOTE: the 512-bit response line is reset too, because downstream sees zero after reset.
            bus.rsp_data     <= '0;
            outstanding      <= '0;
            err              <= 1'b0;
        end else begin
            bus.out_rd_en <= grant_any;
            if (grant_any) begin
                ptr              <= next_ptr;
                bus.out_rd_addr  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                bus.out_rd_mdata <= 16'(grant_idx);
            end

            case ({grant_any, bus.in_rsp_valid})
                2'b10:   outstanding <= outstanding + 10'd1;
                2'b01: begin
                    if (outstanding == 10'd0) err <= 1'b1;
                    else                      outstanding <= outstanding - 10'd1;
                end
                default: outstanding <= outstanding;
            endcase

            bus.rsp_valid <= '0;
            if (bus.in_rsp_valid) begin
                if (rsp_tag_ok) begin
                    bus.rsp_valid[rsp_idx] <= 1'b1;
                    bus.rsp_data           <= bus.in_rsp_data;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef CCI_RD_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_any && (grant_idx == PTR_W'(i)))
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
            end
            if ((|bus.req_valid) && !grant_any) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
